// File: rtl/alu_pipe.sv
// alu_pipe: handshaked RV32I ALU with a registered result and zero flag.
//
// An operand pair and opcode are accepted on a valid/ready input channel. One
// result is presented on a valid/ready output channel. Shifts run on a serial
// one-bit-per-cycle shifter unless ALU_FAST_SHIFT_EN is defined. With the macro
// defined, a combinational barrel shifter is used and every opcode has latency 1.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand/opcode beat is valid
//   in_ready   block can accept a beat this cycle
//   op_a       operand A
//   op_b       operand B; op_b[SHW-1:0] is the shift amount
//   alu_op     4-bit opcode
//   out_valid  result/zero are valid
//   out_ready  consumer accepts the result this cycle
//   result     registered result
//   zero       registered flag, set when result == 0
//   busy       serial shift in progress
//
// Build option: ALU_FAST_SHIFT_EN selects the single-cycle barrel shifter.

module alu_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [3:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b1000;
    localparam logic [3:0] OpAnd  = 4'b0111;
    localparam logic [3:0] OpOr   = 4'b0110;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSll  = 4'b0001;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSra  = 4'b1101;
    localparam logic [3:0] OpSlt  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            sh_left_q, sh_left_d;
    logic            sh_arith_q, sh_arith_d;

    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            serial_start;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] step_res;

    assign shamt  = op_b[SHW-1:0];
    assign accept = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign serial_start = 1'b0;
`else
    logic is_shift;
    assign is_shift     = (alu_op == OpSll) || (alu_op == OpSrl) || (alu_op == OpSra);
    // A zero shift amount is just a pass-through and stays single-cycle.
    assign serial_start = is_shift && (shamt != '0);
`endif

    // Single-cycle result. In the serial build shifts land in the default arm,
    // which is only reached for shamt == 0 and returns op_a unchanged.
    always_comb begin
        alu_res = op_a;
        case (alu_op)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
`ifdef ALU_FAST_SHIFT_EN
            OpSll:   alu_res = op_a << shamt;
            OpSrl:   alu_res = op_a >> shamt;
            OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
`endif
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = op_a;
        endcase
    end

    // One-bit step of the serial shifter.
    always_comb begin
        if (sh_left_q) begin
            step_res = {work_q[XLEN-2:0], 1'b0};
        end else begin
            step_res = {sh_arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && serial_start) state_d = StShift;
            StShift: if (cnt_q == SHW'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
`ifdef ALU_FAST_SHIFT_EN
        busy     = 1'b0;
`else
        busy     = (state_q == StShift);
`endif
    end

    // Datapath next state.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        sh_left_d   = sh_left_q;
        sh_arith_d  = sh_arith_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (serial_start) begin
                        work_d     = op_a;
                        cnt_d      = shamt;
                        sh_left_d  = (alu_op == OpSll);
                        sh_arith_d = (alu_op == OpSra);
                    end else begin
                        // Overrides the consume above: no bubble on back-to-back beats.
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            StShift: begin
                work_d = step_res;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d    = step_res;
                    zero_d      = (step_res == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
            sh_left_q   <= 1'b0;
            sh_arith_q  <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            sh_left_q   <= sh_left_d;
            sh_arith_q  <= sh_arith_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases, throughput, backpressure,
// reset mid-operation and randomized traffic against a behavioural model.
// Define ALU_FAST_SHIFT_EN for both files to exercise the barrel-shifter build.

module tb_alu_pipe;

    localparam int unsigned XLEN = 32;
`ifdef ALU_FAST_SHIFT_EN
    localparam bit Serial = 1'b0;
`else
    localparam bit Serial = 1'b1;
`endif

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b1000;
    localparam logic [3:0] OpAnd  = 4'b0111;
    localparam logic [3:0] OpOr   = 4'b0110;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSll  = 4'b0001;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSra  = 4'b1101;
    localparam logic [3:0] OpSlt  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      alu_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    alu_pipe #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [XLEN-1:0] exp_q[$];
    logic            hold_pending;
    logic [XLEN-1:0] hold_res;
    logic            hold_zero;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish within time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: the opcode table applied with plain arithmetic.
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int unsigned k;
        k = b % XLEN;
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpSll:   return a << k;
            OpSrl:   return a >> k;
            OpSra:   return a[XLEN-1] ? ~((~a) >> k) : (a >> k);
            OpSlt:   return ($signed(a) < $signed(b)) ? 1 : 0;
            OpSltu:  return (a < b) ? 1 : 0;
            default: return a;
        endcase
    endfunction

    function automatic bit is_sh(input logic [3:0] op);
        return (op == OpSll) || (op == OpSrl) || (op == OpSra);
    endfunction

    // One clock: drive inputs, observe handshakes, advance to 1 unit after the edge.
    task automatic cycle(input logic iv, input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic ordy, output logic acc);
        logic [XLEN-1:0] e;
        if (hold_pending) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, hold_res);
            chk("hold_zero", zero, hold_zero);
        end
        in_valid  = iv;
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_result", result, e);
                chk("out_zero", zero, e == 0);
            end
        end
        hold_pending = out_valid && !out_ready;
        hold_res     = result;
        hold_zero    = zero;
        if (acc) exp_q.push_back(ref_alu(op, a, b));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cycle(1'b0, 4'($urandom), $urandom, $urandom, 1'b1, acc);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Single isolated beat; inputs are scrambled while it is in flight.
    task automatic one(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       output logic [XLEN-1:0] res, output logic zr, output int lat,
                       output int bz, output int bzr);
        logic acc = 1'b0;
        int   n   = 0;
        int   c0;
        while (!acc && n < 20) begin
            cycle(1'b1, op, a, b, 1'b1, acc);
            n++;
        end
        chk("accept_timeout", acc, 1);
        c0  = cyc;
        bz  = 0;
        bzr = 0;
        n   = 0;
        while (!out_valid && n < 100) begin
            if (busy) bz++;
            if (busy && !in_ready) bzr++;
            cycle(1'b0, 4'($urandom), $urandom, $urandom, 1'b1, acc);
            n++;
        end
        chk("valid_timeout", out_valid, 1);
        lat = cyc - c0;
        res = result;
        zr  = zero;
        cycle(1'b0, 4'($urandom), $urandom, $urandom, 1'b1, acc);
    endtask

    task automatic dir(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] e);
        logic [XLEN-1:0] res;
        logic            zr;
        int              lat, bz, bzr, k, exp_lat;
        one(op, a, b, res, zr, lat, bz, bzr);
        k       = int'(b % XLEN);
        // Edges after acceptance until out_valid shows; busy is high for the same span.
        exp_lat = (Serial && is_sh(op) && k != 0) ? k : 0;
        chk({tag, "_res"}, res, e);
        chk({tag, "_zero"}, zr, e == 0);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(bz), 64'(exp_lat));
        chk({tag, "_inrdy_low"}, 64'(bzr), 64'(exp_lat));
    endtask

    initial begin
        logic acc;
        int   nacc, nval, nbp;
        logic [XLEN-1:0] ra, rb;

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        alu_op       = '0;
        op_a         = '0;
        op_b         = '0;
        hold_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Reset while a long shift (or, fast build, a held result) is outstanding.
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) cycle(1'b1, OpSll, 32'h0000_0001, 32'd20, 1'b0, acc);
        chk("rstmid_accept", acc, 1);
        for (int i = 0; i < 5; i++) cycle(1'b0, OpAdd, '0, '0, 1'b0, acc);
        chk("rstmid_busy_before", busy, Serial);
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_result", result, 0);
        chk("rstmid_zero", zero, 1);
        chk("rstmid_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        #1;
        chk("rstmid_in_ready", in_ready, 1);
        nval = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) nval++;
            cycle(1'b0, OpAdd, '0, '0, 1'b1, acc);
        end
        chk("rstmid_no_emit", 64'(nval), 0);

        // Directed operations.
        dir("add_wrap", OpAdd, 32'hFFFF_FFFF, 32'h1, 32'h0);
        dir("sub_neg", OpSub, 32'd5, 32'd7, 32'hFFFF_FFFE);
        dir("slt", OpSlt, 32'hFFFF_FFFF, 32'h1, 32'h1);
        dir("sltu", OpSltu, 32'hFFFF_FFFF, 32'h1, 32'h0);
        dir("pass", 4'b1111, 32'h1234, 32'hDEAD_BEEF, 32'h1234);
        dir("and", OpAnd, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        dir("or", OpOr, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
        dir("xor", OpXor, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        dir("sra31", OpSra, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        dir("srl31", OpSrl, 32'h8000_0000, 32'd31, 32'h0000_0001);
        dir("sll31", OpSll, 32'h0000_0003, 32'd31, 32'h8000_0000);
        dir("sll_hi_ign", OpSll, 32'h1, 32'h21, 32'h2);
        dir("sll_k0", OpSll, 32'h1234_5678, 32'h0, 32'h1234_5678);
        dir("sra_pos", OpSra, 32'h7000_0000, 32'd4, 32'h0700_0000);
        dir("sll_iso", OpSll, 32'h0000_00F1, 32'd3, 32'h0000_0788);

        // Back-to-back throughput.
        nacc = 0;
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 1 && i <= 8 && out_valid) nval++;
            if (i < 8) begin
                cycle(1'b1, OpAdd, $urandom, $urandom, 1'b1, acc);
                if (acc) nacc++;
            end else begin
                cycle(1'b0, OpAdd, '0, '0, 1'b1, acc);
            end
        end
        chk("tput_accepts", 64'(nacc), 8);
        chk("tput_valid_run", 64'(nval), 8);
        drain();

        // Backpressure with a queued beat.
        ra = $urandom;
        rb = $urandom;
        cycle(1'b1, OpXor, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, acc);
        chk("bp_first_accept", acc, 1);
        nbp = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, OpSub, ra, rb, 1'b0, acc);
            if (acc) nbp++;
        end
        chk("bp_blocked", 64'(nbp), 0);
        chk("bp_held_result", result, 0);
        chk("bp_held_zero", zero, 1);
        cycle(1'b1, OpSub, ra, rb, 1'b1, acc);
        chk("bp_accept_on_consume", acc, 1);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, ra - rb);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                  $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked ALU for the RV32I datapath: accepts an operand pair and opcode on a valid/ready input channel, computes one result, and presents it on a valid/ready output channel with a registered result and zero flag. It supersedes the fixed-width, single-cycle registered ALU. It adds arithmetic right shift and set-less-than, backpressure, and an optional area-saving serial shifter. It sits between the register-read/operand-mux stage and writeback.

## Interface
- XLEN, 32: datapath width; a power of two, at least 8.
- SHW, $clog2(XLEN): shift-amount width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode beat is valid.
- in_ready  out  1  block can accept a beat this cycle.
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B; bits [SHW-1:0] are the shift amount for shifts.
- alu_op  in  4  opcode; encoding is listed under Operation.
- out_valid  out  1  result/zero are valid.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  XLEN  registered result.
- zero  out  1  registered flag, asserted when result == 0.
- busy  out  1  a serial shift is in progress (SHIFT state).

## Operation
- Opcode encoding:
  - 0000: add.
  - 1000: sub.
  - 0111: and.
  - 0110: or.
  - 0100: xor.
  - 0001: sll.
  - 0101: srl.
  - 1101: sra.
  - 0010: slt (signed compare), result {0…0, op_a<op_b}.
  - 0011: sltu (unsigned compare), same result form.
  - Any other value: result = op_a (pass-through).
- Arithmetic wraps modulo 2^XLEN; no carry or overflow output.
- Shift amount: op_b[SHW-1:0]; upper bits of op_b are ignored. sra replicates op_a[XLEN-1].
- A beat is accepted when in_valid && in_ready. A beat is consumed when out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This allows back-to-back throughput of one beat per cycle for non-serial operations.
- FSM states:
  - IDLE: the output register holds the last result, or nothing.
  - SHIFT: serial shift in progress; only entered without the macro in Configuration.
- Transitions:
  - IDLE → SHIFT when a shift opcode is accepted with shamt ≥ 1 and the serial shifter is compiled in.
  - SHIFT → IDLE when the counter reaches 0; the result is loaded and out_valid is set.
- The output register holds result, zero and out_valid stable while out_valid && !out_ready.
- out_valid clears on consumption unless a new single-cycle beat is accepted in the same cycle, in which case it stays high with the new data.
- Inputs are sampled only at acceptance; later changes to op_a, op_b or alu_op are ignored.

## Timing
- Reset values: out_valid=0, result=0, zero=1, busy=0, state=IDLE, shift counter=0. in_ready is 1 once rst deasserts.
- Reset asserted mid-SHIFT or mid-hold discards the beat; no output appears for it.
- Single-cycle operations: accepted at edge N → out_valid=1 after edge N (latency 1).
- Serial shift with shamt k ≥ 1:
  - Edge N loads the working register with op_a and sets the counter to k.
  - Edges N+1…N+k each shift by one bit and decrement the counter.
  - out_valid rises after edge N+k; latency max(1,k).
  - busy=1 and in_ready=0 from after edge N until after edge N+k.
- Shift with k = 0 completes in 1 cycle and returns op_a.
- Shift with k = XLEN-1: sll/srl leave a single surviving bit; sra fills every bit with the sign.
- out_ready is ignored while out_valid=0.
- Simultaneous consume and accept: the new result replaces the old one at the same edge, with no bubble.

## Configuration
- ALU_FAST_SHIFT_EN defined: a combinational barrel shifter is used. All opcodes, including shifts, have latency 1. The SHIFT state is never entered and busy is tied to 0.
- ALU_FAST_SHIFT_EN undefined: the serial one-bit-per-cycle shifter is used. Shift latency is max(1,shamt) and in_ready is held low during SHIFT. Non-shift opcodes are unaffected.

## Test plan
- Reset: assert rst mid-SHIFT (serial build, sll shamt=20 at cycle 5) → out_valid=0, result=0, zero=1, in_ready=1 after release; the beat is never emitted.
- Arithmetic: add 0xFFFF_FFFF+1 → 0x0000_0000 with zero=1. sub 5-7 → 0xFFFF_FFFE. slt 0xFFFF_FFFF,1 → 1. sltu 0xFFFF_FFFF,1 → 0. Opcode 1111 with op_a=0x1234 → 0x1234.
- Shifts, both builds: sra 0x8000_0000 by 31 → 0xFFFF_FFFF. srl 0x8000_0000 by 31 → 1. sll 1 by op_b=0x21 (shamt 1) → 2. Serial build: the sra completes exactly 31 cycles after acceptance, with busy high throughout.
- Throughput: 8 back-to-back adds with out_ready=1 → 8 results on 8 consecutive cycles, with in_ready constantly 1.
- Backpressure: hold out_ready=0 for 4 cycles after a result → result/zero stable and in_ready=0. Release → the next queued beat is accepted in the same cycle the result is consumed.
- Input isolation: change op_a during a serial sll shamt=3 → result reflects the op_a value sampled at acceptance.
